// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port synchronous memory.
// DM has priority; IF wins after STARVE_MAX consecutive lost arbitrations.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_req,
  input  logic [31:0]      if_addr,
  output logic             if_ack,
  output logic [31:0]      if_rdata,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [31:0]      dm_addr,
  input  logic [31:0]      dm_wdata,
  output logic             dm_ack,
  output logic [31:0]      dm_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [29:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  output logic             err_misalign,
  output logic [CNT_W-1:0] if_grants,
  output logic [CNT_W-1:0] dm_grants
);

  localparam int unsigned WAIT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

  state_t            r_state;
  owner_t            r_owner;
  logic              r_if_ack;
  logic              r_dm_ack;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [29:0]       r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_err_misalign;
  logic [WAIT_W-1:0] r_if_wait;
  logic [CNT_W-1:0]  r_if_grants;
  logic [CNT_W-1:0]  r_dm_grants;

  logic              w_arb;
  logic              w_if_cand;
  logic              w_dm_cand;
  logic              w_if_starved;
  logic              w_grant_if;
  logic              w_grant_dm;
  logic [31:0]       w_gnt_addr;

  // The owner being answered in RESP is masked so a held request cannot re-win.
  always_comb begin
    w_arb        = (r_state == S_IDLE) || (r_state == S_RESP);
    w_if_cand    = if_req && !((r_state == S_RESP) && (r_owner == OWN_IF));
    w_dm_cand    = dm_req && !((r_state == S_RESP) && (r_owner == OWN_DM));
    w_if_starved = (r_if_wait >= WAIT_W'(STARVE_MAX));
    w_grant_if   = w_arb && w_if_cand && (!w_dm_cand || w_if_starved);
    w_grant_dm   = w_arb && w_dm_cand && !w_grant_if;
    w_gnt_addr   = w_grant_if ? if_addr : dm_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_owner        <= OWN_IF;
      r_if_ack       <= 1'b0;
      r_dm_ack       <= 1'b0;
      r_mem_en       <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_err_misalign <= 1'b0;
      r_if_wait      <= '0;
      r_if_grants    <= '0;
      r_dm_grants    <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_dm_ack <= 1'b0;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;

      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_grant_if || w_grant_dm) begin
            r_state     <= S_ISSUE;
            r_owner     <= w_grant_dm ? OWN_DM : OWN_IF;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_grant_dm && dm_we;
            r_mem_addr  <= w_gnt_addr[31:2];
            r_mem_wdata <= dm_wdata;
            if (w_gnt_addr[1:0] != 2'b00) begin
              r_err_misalign <= 1'b1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_state <= S_RESP;
          if (r_owner == OWN_DM) begin
            r_dm_ack <= 1'b1;
          end else begin
            r_if_ack <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_grant_if) begin
        r_if_wait <= '0;
      end else if (w_grant_dm && if_req && !w_if_starved) begin
        r_if_wait <= r_if_wait + WAIT_W'(1);
      end

      if (w_grant_if && (r_if_grants != '1)) begin
        r_if_grants <= r_if_grants + CNT_W'(1);
      end
      if (w_grant_dm && (r_dm_grants != '1)) begin
        r_dm_grants <= r_dm_grants + CNT_W'(1);
      end
    end
  end

  assign if_ack       = r_if_ack;
  assign dm_ack       = r_dm_ack;
  assign if_rdata     = r_if_ack ? mem_rdata : '0;
  assign dm_rdata     = r_dm_ack ? mem_rdata : '0;
  assign mem_en       = r_mem_en;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign err_misalign = r_err_misalign;
  assign if_grants    = r_if_grants;
  assign dm_grants    = r_dm_grants;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a synchronous memory model and
// issue/ack scoreboards; counters are narrowed to exercise saturation.
module tb_mem_port_arbiter;

  localparam int unsigned CW = 3;

  logic          clk;
  logic          rst_n;
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_ack;
  logic [31:0]   if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [31:0]   dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_ack;
  logic [31:0]   dm_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [29:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          err_misalign;
  logic [CW-1:0] if_grants;
  logic [CW-1:0] dm_grants;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        dm;
    logic        chk;
    logic [31:0] data;
  } ack_t;

  typedef struct packed {
    logic [29:0] addr;
    logic        we;
    logic [31:0] wdata;
  } iss_t;

  ack_t ack_q[$];
  iss_t iss_q[$];

  logic [31:0] mem [0:63];

  mem_port_arbiter #(.STARVE_MAX(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_misalign(err_misalign),
    .if_grants(if_grants), .dm_grants(dm_grants)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int unsigned a);
    return 32'h2000_0000 | (a << 16) | (a * 5);
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = pat(i);
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
      mem_rdata <= mem[mem_addr[5:0]];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_iss(input logic [29:0] a, input logic we, input logic [31:0] wd);
    iss_t s;
    s.addr = a; s.we = we; s.wdata = wd;
    iss_q.push_back(s);
  endtask

  task automatic exp_ack(input logic dm, input logic chk, input logic [31:0] d);
    ack_t e;
    e.dm = dm; e.chk = chk; e.data = d;
    ack_q.push_back(e);
  endtask

  // Scoreboard monitor: every memory access and every ack must match the queues in order.
  always @(negedge clk) begin
    iss_t s;
    ack_t e;
    if (rst_n) begin
      check("we_without_en", {63'd0, mem_we & ~mem_en}, 64'd0);
      if (mem_en) begin
        check("iss_expected", {63'd0, iss_q.size() != 0}, 64'd1);
        if (iss_q.size() != 0) begin
          s = iss_q.pop_front();
          check("iss_addr", {34'd0, mem_addr}, {34'd0, s.addr});
          check("iss_we", {63'd0, mem_we}, {63'd0, s.we});
          check("iss_wdata", {32'd0, mem_wdata}, {32'd0, s.wdata});
        end
      end
      if (if_ack || dm_ack) begin
        check("ack_one_hot", {62'd0, if_ack, dm_ack} == 64'd3 ? 64'd1 : 64'd0, 64'd0);
        check("ack_expected", {63'd0, ack_q.size() != 0}, 64'd1);
        if (ack_q.size() != 0) begin
          e = ack_q.pop_front();
          check("ack_port", {63'd0, dm_ack}, {63'd0, e.dm});
          if (e.chk) check("ack_rdata", {32'd0, e.dm ? dm_rdata : if_rdata}, {32'd0, e.data});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;

    #12;
    check("rst_mem_en", {63'd0, mem_en}, 64'd0);
    check("rst_acks", {62'd0, if_ack, dm_ack}, 64'd0);
    check("rst_rdata", {if_rdata, dm_rdata}, 64'd0);
    check("rst_mem_regs", {1'b0, mem_we, mem_addr, mem_wdata}, 64'd0);
    check("rst_flags", {57'd0, err_misalign, if_grants, dm_grants}, 64'd0);

    @(posedge clk); #1;
    rst_n = 1'b1;

    // IF-only read of word 2
    if_addr = 32'h8; if_req = 1'b1;
    exp_iss(30'd2, 1'b0, 32'h0); exp_ack(1'b0, 1'b1, 32'h2002000A);
    step(1);
    check("if_rd_mem_en", {63'd0, mem_en}, 64'd1);
    check("if_rd_mem_addr", {34'd0, mem_addr}, 64'd2);
    check("if_rd_no_ack_yet", {63'd0, if_ack}, 64'd0);
    if_req = 1'b0;
    step(1);
    check("if_rd_ack", {63'd0, if_ack}, 64'd1);
    check("if_rd_rdata", {32'd0, if_rdata}, 64'h2002000A);
    check("if_rd_grants", {61'd0, if_grants}, 64'd1);
    step(1);
    check("if_rd_ack_pulse", {63'd0, if_ack}, 64'd0);

    // DM store then load back
    dm_we = 1'b1; dm_addr = 32'h10; dm_wdata = 32'hDEADBEEF; dm_req = 1'b1;
    exp_iss(30'd4, 1'b1, 32'hDEADBEEF); exp_ack(1'b1, 1'b0, 32'h0);
    step(1);
    check("st_mem_we", {63'd0, mem_we}, 64'd1);
    check("st_mem_addr", {34'd0, mem_addr}, 64'd4);
    check("st_mem_wdata", {32'd0, mem_wdata}, 64'hDEADBEEF);
    dm_req = 1'b0;
    step(1);
    check("st_ack", {63'd0, dm_ack}, 64'd1);
    check("st_grants", {61'd0, dm_grants}, 64'd1);
    step(1);
    check("st_idle_we", {62'd0, mem_we, dm_ack}, 64'd0);
    dm_we = 1'b0; dm_req = 1'b1;
    exp_iss(30'd4, 1'b0, 32'hDEADBEEF); exp_ack(1'b1, 1'b1, 32'hDEADBEEF);
    step(1);
    dm_req = 1'b0;
    step(1);
    check("ld_rdata", {32'd0, dm_rdata}, 64'hDEADBEEF);
    step(1);

    // Both held: DM, IF, DM, IF with acks every second cycle
    if_addr = 32'h20; dm_addr = 32'h24; dm_wdata = 32'h0;
    if_req = 1'b1; dm_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_iss(30'd9, 1'b0, 32'h0); exp_ack(1'b1, 1'b1, pat(9));
      exp_iss(30'd8, 1'b0, 32'h0); exp_ack(1'b0, 1'b1, pat(8));
    end
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (i % 2 == 1) begin
        check("alt_issue_en", {63'd0, mem_en}, 64'd1);
        check("alt_issue_noack", {62'd0, if_ack, dm_ack}, 64'd0);
      end else begin
        check("alt_ack", {62'd0, if_ack, dm_ack}, (i % 4 == 2) ? 64'd1 : 64'd2);
      end
      if (i == 7) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
    end
    step(1);
    check("alt_grants", {58'd0, if_grants, dm_grants}, {58'd0, 3'd3, 3'd4});

    // Misaligned DM load
    dm_addr = 32'h13; dm_req = 1'b1;
    exp_iss(30'd4, 1'b0, 32'h0); exp_ack(1'b1, 1'b1, 32'hDEADBEEF);
    step(1);
    check("mis_flag", {63'd0, err_misalign}, 64'd1);
    check("mis_addr", {34'd0, mem_addr}, 64'd4);
    dm_req = 1'b0;
    step(2);
    check("mis_sticky", {63'd0, err_misalign}, 64'd1);
    check("mis_grants", {61'd0, dm_grants}, 64'd5);

    // IF access while dm_we is high must not write
    dm_we = 1'b1; dm_wdata = 32'h12345678; if_addr = 32'hC; if_req = 1'b1;
    exp_iss(30'd3, 1'b0, 32'h12345678); exp_ack(1'b0, 1'b1, pat(3));
    step(1);
    check("if_no_write", {62'd0, mem_en, mem_we}, 64'd2);
    if_req = 1'b0; dm_we = 1'b0; dm_wdata = 32'h0;
    step(2);
    check("if_nw_grants", {61'd0, if_grants}, 64'd4);

    // Starvation: IF requests only at IDLE arbitration edges while DM stays requesting
    dm_addr = 32'h30; if_addr = 32'h40; dm_req = 1'b1;
    for (int r = 1; r <= 5; r++) begin
      if_req = 1'b1;
      if (r < 5) begin
        exp_iss(30'd12, 1'b0, 32'h0); exp_ack(1'b1, 1'b1, pat(12));
      end else begin
        exp_iss(30'd16, 1'b0, 32'h0); exp_ack(1'b0, 1'b1, pat(16));
        exp_iss(30'd12, 1'b0, 32'h0); exp_ack(1'b1, 1'b1, pat(12));
      end
      step(1);
      check("starve_winner", {34'd0, mem_addr}, (r < 5) ? 64'd12 : 64'd16);
      if_req = 1'b0;
      step(2);
    end
    step(2);
    if_req = 1'b1;
    exp_iss(30'd12, 1'b0, 32'h0); exp_ack(1'b1, 1'b1, pat(12));
    step(1);
    check("wait_cleared_dm_wins", {34'd0, mem_addr}, 64'd12);
    if_req = 1'b0; dm_req = 1'b0;
    step(3);
    check("sat_grants", {58'd0, if_grants, dm_grants}, {58'd0, 3'd5, 3'd7});

    // Reset during ISSUE abandons the access
    dm_addr = 32'h8; dm_req = 1'b1;
    step(1);
    check("rst_issue_en", {63'd0, mem_en}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_en", {62'd0, mem_en, mem_we}, 64'd0);
    check("rst_async_cnt", {57'd0, err_misalign, if_grants, dm_grants}, 64'd0);
    dm_req = 1'b0;
    step(2);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("rst_no_ack", {61'd0, if_ack, dm_ack, mem_en}, 64'd0);
    end

    check("ack_q_drained", ack_q.size(), 64'd0);
    check("iss_q_drained", iss_q.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
